// File: rtl/k12a_sequencer.sv
// K12A fetch/execute sequencer: multi-byte fetch with wait states, execute, rjmp, halt, stall fault.
// Define K12A_SEQ_IRQ_EN to add the irq/irq_ack ports and the one-cycle IRQ state.
module k12a_sequencer #(
  parameter int unsigned INST_BYTES   = 2,
  parameter int unsigned IDX_W        = 2,
  parameter int unsigned WAIT_TIMEOUT = 15,
  parameter int unsigned TO_W         = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             skip,
  input  logic             exec_done,
  input  logic             exec_rjmp,
  input  logic             exec_halt,
  input  logic             mem_ready,
  input  logic             wake,
`ifdef K12A_SEQ_IRQ_EN
  input  logic             irq,
  output logic             irq_ack,
`endif
  output logic [2:0]       state,
  output logic [IDX_W-1:0] fetch_index,
  output logic             mem_req,
  output logic             inst_byte_store,
  output logic             pc_inc,
  output logic             pc_skip,
  output logic             pc_rel,
  output logic             fault
);

`ifdef K12A_SEQ_IRQ_EN
  typedef enum logic [2:0] {
    StFetch = 3'd0, StExec = 3'd1, StRjmp = 3'd2, StHalt = 3'd3, StFault = 3'd4, StIrq = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    StFetch = 3'd0, StExec = 3'd1, StRjmp = 3'd2, StHalt = 3'd3, StFault = 3'd4
  } state_e;
`endif

  localparam logic [IDX_W-1:0] LastIdx   = IDX_W'(INST_BYTES - 1);
  localparam logic [TO_W-1:0]  WaitLast  = TO_W'(WAIT_TIMEOUT > 0 ? WAIT_TIMEOUT - 1 : 0);
  localparam bit               TimeoutEn = (WAIT_TIMEOUT != 0);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [TO_W-1:0]  wait_cnt_q;
  logic             fault_q;
  logic             skip_now;
  logic             fetching;

  // Skip only applies at the start of an instruction; it suppresses the memory access.
  assign skip_now = (state_q == StFetch) && (idx_q == '0) && skip;
  assign fetching = reset_n && (state_q == StFetch) && !skip_now;

  assign state           = state_q;
  assign fetch_index     = idx_q;
  assign fault           = fault_q;
  assign mem_req         = fetching;
  assign inst_byte_store = fetching && mem_ready;
  assign pc_inc          = fetching && mem_ready;
  assign pc_skip         = reset_n && skip_now;
  assign pc_rel          = reset_n && (state_q == StRjmp);
`ifdef K12A_SEQ_IRQ_EN
  assign irq_ack         = reset_n && (state_q == StIrq);
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= StFetch;
      idx_q      <= '0;
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (skip_now) begin
            wait_cnt_q <= '0;
          end else if (mem_ready) begin
            wait_cnt_q <= '0;
            if (idx_q == LastIdx) begin
              idx_q   <= '0;
              state_q <= StExec;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else if (TimeoutEn && (wait_cnt_q == WaitLast)) begin
            // This stall cycle is the WAIT_TIMEOUT-th in a row.
            wait_cnt_q <= '0;
            state_q    <= StFault;
            fault_q    <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StExec: begin
          if (exec_done) begin
            if (exec_halt) begin
              state_q <= StHalt;
`ifdef K12A_SEQ_IRQ_EN
            end else if (irq) begin
              state_q <= StIrq;
`endif
            end else if (exec_rjmp) begin
              state_q <= StRjmp;
            end else begin
              state_q <= StFetch;
            end
          end
        end
        StRjmp: state_q <= StFetch;
        StHalt: begin
`ifdef K12A_SEQ_IRQ_EN
          if (irq) begin
            state_q <= StIrq;
          end else if (wake) begin
            state_q <= StFetch;
          end
`else
          if (wake) begin
            state_q <= StFetch;
          end
`endif
        end
`ifdef K12A_SEQ_IRQ_EN
        StIrq: state_q <= StFetch;
`endif
        StFault: state_q <= StFault;
        default: state_q <= StFetch;
      endcase
    end
  end

endmodule
